// File: rtl/decode_wide.sv
// WIDTH-lane decode / ROB-tag allocate stage with a one-entry registered output group.
// Accepts an in-order prefix of queued instructions bounded by ROB free space.
module decode_wide #(
  parameter  int WIDTH     = 2,
  parameter  int ROB_DEPTH = 16,
  localparam int TW        = $clog2(ROB_DEPTH),
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [63:0]         flush_order,
  input  logic [WIDTH-1:0]    in_valid,
  input  logic [32*WIDTH-1:0] in_instr,
  input  logic [32*WIDTH-1:0] in_pc,
  output logic [CW-1:0]       in_take,
  input  logic [TW:0]         rob_free,
  input  logic [TW-1:0]       rob_base,
  output logic [CW-1:0]       rob_alloc,
  output logic [WIDTH-1:0]    out_valid,
  input  logic                out_ready,
  output logic [7*WIDTH-1:0]  out_opcode,
  output logic [3*WIDTH-1:0]  out_funct3,
  output logic [5*WIDTH-1:0]  out_rs1,
  output logic [5*WIDTH-1:0]  out_rs2,
  output logic [5*WIDTH-1:0]  out_rd,
  output logic [32*WIDTH-1:0] out_imm,
  output logic [3*WIDTH-1:0]  out_fu,
  output logic [WIDTH-1:0]    out_use_imm,
  output logic [32*WIDTH-1:0] out_pc,
  output logic [TW*WIDTH-1:0] out_rob_tag,
  output logic [64*WIDTH-1:0] out_order
);

  typedef struct packed {
    logic [2:0]  fu;
    logic        useImm;
    logic [4:0]  rd;
    logic [31:0] imm;
  } dec_t;

  // Every legal non-OP format consumes an immediate operand.
  function automatic dec_t decodeLane(input logic [31:0] ins);
    dec_t d;
    d.fu     = 3'd7;
    d.useImm = 1'b0;
    d.rd     = ins[11:7];
    d.imm    = '0;
    case (ins[6:0])
      7'b0110011: d.fu = (ins[31:25] == 7'b0000001) ? (ins[14] ? 3'd2 : 3'd1) : 3'd0;
      7'b0010011: begin d.fu = 3'd0; d.useImm = 1'b1; d.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0110111,
      7'b0010111: begin d.fu = 3'd0; d.useImm = 1'b1; d.imm = {ins[31:12], 12'b0}; end
      7'b0000011: begin d.fu = 3'd3; d.useImm = 1'b1; d.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0100011: begin
        d.fu = 3'd3; d.useImm = 1'b1; d.rd = '0;
        d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        d.fu = 3'd4; d.useImm = 1'b1; d.rd = '0;
        d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b1101111: begin
        d.fu = 3'd4; d.useImm = 1'b1;
        d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111: begin d.fu = 3'd4; d.useImm = 1'b1; d.imm = {{20{ins[31]}}, ins[31:20]}; end
      default:    d.rd = '0;
    endcase
    return d;
  endfunction

  logic [WIDTH-1:0]    validQ, validD;
  logic [7*WIDTH-1:0]  opcodeQ, opcodeD;
  logic [3*WIDTH-1:0]  funct3Q, funct3D, fuQ, fuD;
  logic [5*WIDTH-1:0]  rs1Q, rs1D, rs2Q, rs2D, rdQ, rdD;
  logic [32*WIDTH-1:0] immQ, immD, pcQ, pcD;
  logic [WIDTH-1:0]    useImmQ, useImmD;
  logic [TW*WIDTH-1:0] tagQ, tagD;
  logic [64*WIDTH-1:0] orderQ, orderD;
  logic [63:0]         orderCntQ, orderCntD;
  logic [CW-1:0]       nLead, take;
  logic                load;

  // Lanes behind the first empty lane are never taken, even if valid.
  always_comb begin
    logic stop;
    nLead = '0;
    stop  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!stop && in_valid[i]) nLead = nLead + CW'(1);
      else                      stop  = 1'b1;
    end
    load = !flush && (!(|validQ) || out_ready);
    take = '0;
    if (load) take = (int'(rob_free) < int'(nLead)) ? CW'(rob_free) : nLead;
    orderCntD = flush ? flush_order : orderCntQ + 64'(take);
  end

  assign in_take   = take;
  assign rob_alloc = take;

  always_comb begin
    dec_t dec;
    validD  = '0;
    opcodeD = '0; funct3D = '0; fuD = '0;
    rs1D    = '0; rs2D    = '0; rdD = '0;
    immD    = '0; pcD     = '0; useImmD = '0;
    tagD    = '0; orderD  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec = decodeLane(in_instr[32*i +: 32]);
      validD[i]           = (i < int'(take));
      opcodeD[7*i +: 7]   = in_instr[32*i +: 7];
      funct3D[3*i +: 3]   = in_instr[32*i+12 +: 3];
      rs1D[5*i +: 5]      = in_instr[32*i+15 +: 5];
      rs2D[5*i +: 5]      = in_instr[32*i+20 +: 5];
      rdD[5*i +: 5]       = dec.rd;
      fuD[3*i +: 3]       = dec.fu;
      immD[32*i +: 32]    = dec.imm;
      useImmD[i]          = dec.useImm;
      pcD[32*i +: 32]     = in_pc[32*i +: 32];
      tagD[TW*i +: TW]    = rob_base + TW'(i);
      orderD[64*i +: 64]  = orderCntQ + 64'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ  <= '0; opcodeQ <= '0; funct3Q <= '0; fuQ <= '0;
      rs1Q    <= '0; rs2Q    <= '0; rdQ     <= '0; immQ <= '0;
      pcQ     <= '0; useImmQ <= '0; tagQ    <= '0; orderQ <= '0;
      orderCntQ <= '0;
    end else begin
      orderCntQ <= orderCntD;
      if (flush) begin
        validQ <= '0;
      end else if (load) begin
        validQ  <= validD;  opcodeQ <= opcodeD; funct3Q <= funct3D; fuQ <= fuD;
        rs1Q    <= rs1D;    rs2Q    <= rs2D;    rdQ     <= rdD;     immQ <= immD;
        pcQ     <= pcD;     useImmQ <= useImmD; tagQ    <= tagD;    orderQ <= orderD;
      end
    end
  end

  assign out_valid   = validQ;
  assign out_opcode  = opcodeQ;
  assign out_funct3  = funct3Q;
  assign out_rs1     = rs1Q;
  assign out_rs2     = rs2Q;
  assign out_rd      = rdQ;
  assign out_imm     = immQ;
  assign out_fu      = fuQ;
  assign out_use_imm = useImmQ;
  assign out_pc      = pcQ;
  assign out_rob_tag = tagQ;
  assign out_order   = orderQ;

endmodule

// File: tb/tb_decode_wide.sv
// Table-driven scoreboard bench for decode_wide at WIDTH=2, ROB_DEPTH=16.
// Expected groups are queued when a row is driven and compared after the edge.
module tb_decode_wide;

  localparam int WIDTH = 2;
  localparam int TW    = 4;
  localparam int CW    = 2;

  localparam logic [31:0] ADDI5  = 32'h00500093;
  localparam logic [31:0] ADDIM1 = 32'hFFF08113;
  localparam logic [31:0] MUL    = 32'h022081B3;
  localparam logic [31:0] REMU   = 32'h0220F233;
  localparam logic [31:0] SW     = 32'h0020A623;
  localparam logic [31:0] BEQ    = 32'hFE208CE3;
  localparam logic [31:0] ILL    = 32'h00000FFF;
  localparam logic [31:0] LUI    = 32'h123452B7;

  logic                clk, rst_n, flush, out_ready;
  logic [63:0]         flush_order;
  logic [WIDTH-1:0]    in_valid, out_valid, out_use_imm;
  logic [32*WIDTH-1:0] in_instr, in_pc, out_imm, out_pc;
  logic [CW-1:0]       in_take, rob_alloc;
  logic [TW:0]         rob_free;
  logic [TW-1:0]       rob_base;
  logic [7*WIDTH-1:0]  out_opcode;
  logic [3*WIDTH-1:0]  out_funct3, out_fu;
  logic [5*WIDTH-1:0]  out_rs1, out_rs2, out_rd;
  logic [TW*WIDTH-1:0] out_rob_tag;
  logic [64*WIDTH-1:0] out_order;

  decode_wide #(.WIDTH(WIDTH), .ROB_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_order(flush_order),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_take(in_take),
    .rob_free(rob_free), .rob_base(rob_base), .rob_alloc(rob_alloc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_fu(out_fu), .out_use_imm(out_use_imm), .out_pc(out_pc),
    .out_rob_tag(out_rob_tag), .out_order(out_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   valid;
    logic [5:0]   fu;
    logic [9:0]   rd;
    logic [63:0]  imm;
    logic [7:0]   tag;
    logic [127:0] ord;
    logic [1:0]   ui;
    logic [1:0]   uiChk;
  } exp_t;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] ins0, ins1;
    logic [3:0]  base;
    logic [4:0]  free;
    logic        ready, fl;
    logic [63:0] fOrder;
    logic [1:0]  take;
    logic        hold;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic exp_t mkExp(input logic [1:0] v, input logic [5:0] fu, input logic [9:0] rd,
                                 input logic [63:0] imm, input logic [7:0] tag,
                                 input logic [127:0] ord, input logic [1:0] ui, input logic [1:0] uiChk);
    exp_t e;
    e.valid = v; e.fu = fu; e.rd = rd; e.imm = imm;
    e.tag = tag; e.ord = ord; e.ui = ui; e.uiChk = uiChk;
    return e;
  endfunction

  task automatic addVec(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [3:0] base, input logic [4:0] free, input logic ready,
                        input logic fl, input logic [63:0] fo, input logic [1:0] take,
                        input logic hold, input exp_t e);
    vec_t r;
    r.valid = v; r.ins0 = i0; r.ins1 = i1; r.base = base; r.free = free;
    r.ready = ready; r.fl = fl; r.fOrder = fo; r.take = take; r.hold = hold; r.e = e;
    vecs.push_back(r);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compareGroup(input string tag, input exp_t e);
    checkOutput($sformatf("%s out_valid", tag), 64'(out_valid), 64'(e.valid));
    for (int i = 0; i < WIDTH; i++) begin
      if (e.valid[i]) begin
        checkOutput($sformatf("%s lane%0d fu", tag, i), 64'(out_fu[3*i +: 3]), 64'(e.fu[3*i +: 3]));
        checkOutput($sformatf("%s lane%0d rd", tag, i), 64'(out_rd[5*i +: 5]), 64'(e.rd[5*i +: 5]));
        checkOutput($sformatf("%s lane%0d imm", tag, i), 64'(out_imm[32*i +: 32]), 64'(e.imm[32*i +: 32]));
        checkOutput($sformatf("%s lane%0d tag", tag, i), 64'(out_rob_tag[TW*i +: TW]), 64'(e.tag[4*i +: 4]));
        checkOutput($sformatf("%s lane%0d order", tag, i), out_order[64*i +: 64], e.ord[64*i +: 64]);
        checkOutput($sformatf("%s lane%0d pc", tag, i), 64'(out_pc[32*i +: 32]), 64'(32'h1000 + 32'(4*i)));
        if (e.uiChk[i])
          checkOutput($sformatf("%s lane%0d use_imm", tag, i), 64'(out_use_imm[i]), 64'(e.ui[i]));
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [3:0] base, input logic [4:0] free, input logic ready,
                               input logic fl, input logic [63:0] fo);
    in_valid = v; in_instr = {i1, i0}; in_pc = {32'h1004, 32'h1000};
    rob_base = base; rob_free = free; out_ready = ready; flush = fl; flush_order = fo;
  endtask

  initial begin
    exp_t zero, last, got;
    zero = '0;
    last = '0;

    addVec(2'b11, ADDI5, ADDIM1, 4'd14, 5'd8, 1, 0, 0, 2'd2, 0,
           mkExp(2'b11, {3'd0,3'd0}, {5'd2,5'd1}, {32'hFFFFFFFF,32'd5}, {4'd15,4'd14}, {64'd1,64'd0}, 2'b11, 2'b11));
    addVec(2'b11, MUL, REMU, 4'd15, 5'd8, 1, 0, 0, 2'd2, 0,
           mkExp(2'b11, {3'd2,3'd1}, {5'd4,5'd3}, 64'd0, {4'd0,4'd15}, {64'd3,64'd2}, 2'b00, 2'b11));
    addVec(2'b11, SW, BEQ, 4'd1, 5'd1, 1, 0, 0, 2'd1, 0,
           mkExp(2'b01, {3'd0,3'd3}, 10'd0, {32'd0,32'd12}, {4'd0,4'd1}, {64'd0,64'd4}, 2'b00, 2'b00));
    addVec(2'b11, BEQ, ILL, 4'd2, 5'd8, 1, 0, 0, 2'd2, 0,
           mkExp(2'b11, {3'd7,3'd4}, 10'd0, {32'd0,32'hFFFFFFF8}, {4'd3,4'd2}, {64'd6,64'd5}, 2'b00, 2'b00));
    addVec(2'b10, ADDI5, ADDI5, 4'd4, 5'd8, 1, 0, 0, 2'd0, 0, zero);
    addVec(2'b11, LUI, ADDI5, 4'd4, 5'd8, 1, 0, 0, 2'd2, 0,
           mkExp(2'b11, {3'd0,3'd0}, {5'd1,5'd5}, {32'd5,32'h12345000}, {4'd5,4'd4}, {64'd8,64'd7}, 2'b11, 2'b11));
    for (int s = 0; s < 3; s++)
      addVec(2'b11, MUL, REMU, 4'd6, 5'd8, 0, 0, 0, 2'd0, 1, zero);
    addVec(2'b11, MUL, REMU, 4'd6, 5'd8, 1, 0, 0, 2'd2, 0,
           mkExp(2'b11, {3'd2,3'd1}, {5'd4,5'd3}, 64'd0, {4'd7,4'd6}, {64'd10,64'd9}, 2'b00, 2'b11));
    addVec(2'b11, MUL, REMU, 4'd8, 5'd8, 1, 1, 64'd100, 2'd0, 0, zero);
    addVec(2'b01, ADDI5, ADDI5, 4'd8, 5'd8, 1, 0, 0, 2'd1, 0,
           mkExp(2'b01, 6'd0, {5'd0,5'd1}, {32'd0,32'd5}, {4'd0,4'd8}, {64'd0,64'd100}, 2'b01, 2'b01));
    addVec(2'b11, ADDI5, ADDI5, 4'd9, 5'd0, 1, 0, 0, 2'd0, 0, zero);
    addVec(2'b11, ADDI5, ADDIM1, 4'd9, 5'd8, 1, 0, 0, 2'd2, 0,
           mkExp(2'b11, 6'd0, {5'd2,5'd1}, {32'hFFFFFFFF,32'd5}, {4'd10,4'd9}, {64'd102,64'd101}, 2'b11, 2'b11));
    addVec(2'b11, ADDI5, ADDI5, 4'd11, 5'd8, 0, 1, 64'd200, 2'd0, 0, zero);
    addVec(2'b01, ADDI5, ADDI5, 4'd11, 5'd8, 0, 0, 0, 2'd1, 0,
           mkExp(2'b01, 6'd0, {5'd0,5'd1}, {32'd0,32'd5}, {4'd0,4'd11}, {64'd0,64'd200}, 2'b01, 2'b01));

    rst_n = 1'b0;
    applyStimulus(2'b00, 32'd0, 32'd0, 4'd0, 5'd8, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_order", out_order[63:0], 64'd0);
    checkOutput("reset out_rob_tag", 64'(out_rob_tag), 64'd0);
    checkOutput("reset out_imm", out_imm[63:0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      applyStimulus(vecs[r].valid, vecs[r].ins0, vecs[r].ins1, vecs[r].base, vecs[r].free,
                    vecs[r].ready, vecs[r].fl, vecs[r].fOrder);
      #1;
      checkOutput($sformatf("row%0d in_take", r), 64'(in_take), 64'(vecs[r].take));
      checkOutput($sformatf("row%0d rob_alloc", r), 64'(rob_alloc), 64'(vecs[r].take));
      if (!vecs[r].hold) last = vecs[r].e;
      sb.push_back(last);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL row%0d scoreboard: got empty queue, expected one entry", r);
      end else begin
        got = sb.pop_front();
        compareGroup($sformatf("row%0d", r), got);
      end
    end

    // Held group must vanish on asynchronous reset, without a clock edge.
    @(negedge clk);
    applyStimulus(2'b11, ADDI5, ADDI5, 4'd0, 5'd8, 0, 0, 0);
    #1;
    checkOutput("stall in_take", 64'(in_take), 64'd0);
    checkOutput("stall held valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("async reset out_order", out_order[63:0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b01, ADDI5, ADDI5, 4'd3, 5'd8, 1, 0, 0);
    #1;
    checkOutput("post reset in_take", 64'(in_take), 64'd1);
    @(posedge clk);
    #1;
    compareGroup("post reset", mkExp(2'b01, 6'd0, {5'd0,5'd1}, {32'd0,32'd5}, {4'd0,4'd3},
                                     {64'd0,64'd0}, 2'b01, 2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
